// File: rtl/mem_arb_if.sv
// mem_arb_if: bundle of the eJ32 port, the host burst port and the byte-memory
// port around the memory arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives memory and status)
//   master : environment view (eJ32, host and memory model together)
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> arbiter, cpu_rdata/cpu_stall <- arbiter
//   host_req/host_we/host_addr/host_len/host_wdata -> arbiter
//   host_beat/host_rvalid/host_rdata/host_busy/host_done <- arbiter
//   mem_addr/mem_we/mem_wdata <- arbiter, mem_rdata -> arbiter (one-cycle read latency)
interface mem_arb_if #(
  parameter int unsigned ASZ = 17
) ();
  logic           cpu_req;
  logic           cpu_we;
  logic [ASZ-1:0] cpu_addr;
  logic [7:0]     cpu_wdata;
  logic [7:0]     cpu_rdata;
  logic           cpu_stall;

  logic           host_req;
  logic           host_we;
  logic [ASZ-1:0] host_addr;
  logic [ASZ-1:0] host_len;
  logic [7:0]     host_wdata;
  logic           host_beat;
  logic           host_rvalid;
  logic [7:0]     host_rdata;
  logic           host_busy;
  logic           host_done;

  logic [ASZ-1:0] mem_addr;
  logic           mem_we;
  logic [7:0]     mem_wdata;
  logic [7:0]     mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_len, host_wdata,
    output host_beat, host_rvalid, host_rdata, host_busy, host_done,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_len, host_wdata,
    input  host_beat, host_rvalid, host_rdata, host_busy, host_done,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: shares one byte-wide memory port between the eJ32 core and a host
// loader/dump port that moves bursts of bytes.
//
// Ports:
//   clk    : system clock, all state on its rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_arb_if.slave (eJ32 port, host burst port, memory port)
// Parameters:
//   ASZ      : byte-address width (also the width of the burst length)
//   FAIR_MAX : eJ32-serviced cycles a waiting host tolerates before it takes a slot
//
// Build option: define MEM_ARB_FAIR_EN to give the host a guaranteed beat after
// FAIR_MAX consecutive starved cycles. Without it the eJ32 has strict priority
// and the host only beats in cycles where cpu_req is low.
//
// Behaviour summary:
//   IDLE  : eJ32 drives the memory port; host_req latches a burst and moves to BURST.
//   BURST : the host beats when the eJ32 is not requesting (or on a fairness slot);
//           the eJ32 is stalled only in cycles where it requests and the host beats.
//   host_done is registered: it appears the cycle after the last beat, together with
//   the return to IDLE. A zero-length burst pulses host_done in its only BURST cycle.
module mem_arb #(
  parameter int unsigned ASZ      = 17,
  parameter int unsigned FAIR_MAX = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_arb_if.slave  bus
);

  // Elaboration-time sanity check on the configuration.
  if (ASZ < 1 || FAIR_MAX < 1) begin : g_param_check
    $error("mem_arb: ASZ and FAIR_MAX must both be at least 1");
  end

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e         state_q, state_d;
  logic [ASZ-1:0] haddr_q, haddr_d;
  logic [ASZ-1:0] rem_q, rem_d;
  logic           hwe_q, hwe_d;
  logic           done_q, done_d;
  logic           rvalid_q, rvalid_d;
  logic           beat;
  logic           fair_slot;

`ifdef MEM_ARB_FAIR_EN
  localparam int unsigned SW = $clog2(FAIR_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;

  // Host has waited long enough: it wins this cycle even if the eJ32 requests.
  assign fair_slot = (starve_q == SW'(FAIR_MAX));
`else
  assign fair_slot = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    rem_d    = rem_q;
    hwe_d    = hwe_q;
    done_d   = 1'b0;
    rvalid_d = 1'b0;
    beat     = 1'b0;
`ifdef MEM_ARB_FAIR_EN
    starve_d = starve_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.host_req) begin
          haddr_d = bus.host_addr;
          rem_d   = bus.host_len;
          hwe_d   = bus.host_we;
          state_d = StBurst;
          // Zero-length burst: done shows up in the single BURST cycle.
          done_d  = (bus.host_len == '0);
`ifdef MEM_ARB_FAIR_EN
          starve_d = '0;
`endif
        end
      end
      StBurst: begin
        if (rem_q == '0) begin
          state_d = StIdle;
        end else if (!bus.cpu_req || fair_slot) begin
          beat     = 1'b1;
          haddr_d  = haddr_q + ASZ'(1);
          rem_d    = rem_q - ASZ'(1);
          rvalid_d = !hwe_q;
`ifdef MEM_ARB_FAIR_EN
          starve_d = '0;
`endif
          if (rem_q == ASZ'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
`ifdef MEM_ARB_FAIR_EN
          starve_d = starve_q + SW'(1);
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory-port steering and status outputs.
  always_comb begin
    bus.mem_addr    = bus.cpu_addr;
    bus.mem_we      = bus.cpu_req & bus.cpu_we;
    bus.mem_wdata   = bus.cpu_wdata;
    bus.cpu_stall   = 1'b0;
    bus.host_beat   = 1'b0;
    if (!rst_n) begin
      // Hold the memory port quiet while reset is asserted.
      bus.mem_addr = '0;
      bus.mem_we   = 1'b0;
    end else if (beat) begin
      bus.mem_addr  = haddr_q;
      bus.mem_we    = hwe_q;
      bus.mem_wdata = bus.host_wdata;
      bus.host_beat = 1'b1;
      bus.cpu_stall = bus.cpu_req;
    end
  end

  assign bus.host_busy   = (state_q == StBurst);
  assign bus.host_done   = done_q;
  assign bus.host_rvalid = rvalid_q;
  assign bus.host_rdata  = bus.mem_rdata;
  assign bus.cpu_rdata   = bus.mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      haddr_q  <= '0;
      rem_q    <= '0;
      hwe_q    <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      rem_q    <= rem_d;
      hwe_q    <= hwe_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
    end
  end

`ifdef MEM_ARB_FAIR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb with a byte-memory model (one-cycle
// read latency). Inputs change 1 ns after the rising edge; outputs are checked
// on the falling edge. Fairness expectations follow MEM_ARB_FAIR_EN.
module tb_mem_arb;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  mem_arb_if #(.ASZ(17)) bus ();

  mem_arb #(
    .ASZ      (17),
    .FAIR_MAX (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Byte memory model.
  logic [7:0] mem [0:131071];
  logic [7:0] rdata_q;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    rdata_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic we, input logic [16:0] addr, input logic [16:0] len,
                             input logic [7:0] wdata);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_len   = len;
    bus.host_wdata = wdata;
  endtask

  logic exp_beat;
  int   nbeat;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.cpu_req    = 1'b1;
    bus.cpu_we     = 1'b1;
    bus.cpu_addr   = 17'h00155;
    bus.cpu_wdata  = 8'hEE;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_len   = '0;
    bus.host_wdata = '0;

    // Reset state.
    #2;
    check("rst_busy",   bus.host_busy,   0);
    check("rst_done",   bus.host_done,   0);
    check("rst_rvalid", bus.host_rvalid, 0);
    check("rst_beat",   bus.host_beat,   0);
    check("rst_stall",  bus.cpu_stall,   0);
    check("rst_mem_we", bus.mem_we,      0);
    check("rst_addr",   bus.mem_addr,    0);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    next_cycle();

    // Write burst of 4 bytes at 0x1000.
    start_burst(1'b1, 17'h01000, 17'd4, 8'h41);
    @(negedge clk);
    check("t1_idle_busy", bus.host_busy, 0);
    next_cycle();
    bus.host_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_beat",  bus.host_beat, 1);
      check("t1_addr",  bus.mem_addr,  32'h1000 + i);
      check("t1_we",    bus.mem_we,    1);
      check("t1_wdata", bus.mem_wdata, 32'h41 + i);
      check("t1_busy",  bus.host_busy, 1);
      check("t1_ndone", bus.host_done, 0);
      next_cycle();
      bus.host_wdata = 8'(8'h42 + i);
    end
    @(negedge clk);
    check("t1_done",  bus.host_done, 1);
    check("t1_idle",  bus.host_busy, 0);
    check("t1_nbeat", bus.host_beat, 0);
    next_cycle();
    @(negedge clk);
    check("t1_pulse", bus.host_done, 0);
    next_cycle();

    // eJ32 reads back 0x1000..0x1003.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 17'(32'h1000 + i);
      end else begin
        bus.cpu_req = 1'b0;
      end
      @(negedge clk);
      if (i > 0) check("t1_rd", bus.cpu_rdata, 32'h41 + i - 1);
      if (i < 4) check("t1_rd_stall", bus.cpu_stall, 0);
      next_cycle();
    end

    // eJ32 writes 0xA0..0xA2 at 0x1400, then a 3-byte host read burst.
    for (int i = 0; i < 3; i++) begin
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 17'(32'h1400 + i);
      bus.cpu_wdata = 8'(8'hA0 + i);
      @(negedge clk);
      check("t2_cpu_we",   bus.mem_we,   1);
      check("t2_cpu_addr", bus.mem_addr, 32'h1400 + i);
      next_cycle();
    end
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    start_burst(1'b0, 17'h01400, 17'd3, 8'h00);
    @(negedge clk);
    next_cycle();
    // Request stays high with new values while busy: it must be ignored.
    bus.host_addr = 17'h00000;
    bus.host_len  = 17'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_beat",   bus.host_beat,   1);
      check("t2_addr",   bus.mem_addr,    32'h1400 + i);
      check("t2_we",     bus.mem_we,      0);
      check("t2_rvalid", bus.host_rvalid, (i > 0) ? 1 : 0);
      if (i > 0) check("t2_rdata", bus.host_rdata, 32'hA0 + i - 1);
      next_cycle();
    end
    bus.host_req = 1'b0;
    @(negedge clk);
    check("t2_done",   bus.host_done,   1);
    check("t2_rvalid", bus.host_rvalid, 1);
    check("t2_rdata",  bus.host_rdata,  32'hA2);
    check("t2_idle",   bus.host_busy,   0);
    next_cycle();
    @(negedge clk);
    check("t2_norestart", bus.host_busy,   0);
    check("t2_rv_end",    bus.host_rvalid, 0);
    next_cycle();

    // eJ32 holds cpu_req during a 2-byte host write burst.
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 17'h01000;
    start_burst(1'b1, 17'h01800, 17'd2, 8'h77);
    @(negedge clk);
    check("t3_idle_stall", bus.cpu_stall, 0);
    next_cycle();
    bus.host_req = 1'b0;
    nbeat = 0;
    for (int i = 0; i < 18; i++) begin
`ifdef MEM_ARB_FAIR_EN
      exp_beat = ((i % 9) == 8);
`else
      exp_beat = 1'b0;
`endif
      @(negedge clk);
      check("t3_beat",  bus.host_beat, exp_beat);
      check("t3_stall", bus.cpu_stall, exp_beat);
      check("t3_busy",  bus.host_busy, 1);
      if (exp_beat) begin
        check("t3_addr", bus.mem_addr, 32'h1800 + nbeat);
        nbeat++;
      end
      next_cycle();
      if (exp_beat) bus.host_wdata = 8'h78;
    end
`ifndef MEM_ARB_FAIR_EN
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t3_late_beat", bus.host_beat, 1);
      check("t3_late_addr", bus.mem_addr,  32'h1800 + i);
      next_cycle();
      bus.host_wdata = 8'h78;
    end
`endif
    @(negedge clk);
    check("t3_done", bus.host_done, 1);
    next_cycle();
    bus.cpu_req = 1'b0;

    // Address wrap at the top of the space.
    start_burst(1'b1, 17'h1FFFF, 17'd2, 8'h5A);
    @(negedge clk);
    next_cycle();
    bus.host_req = 1'b0;
    @(negedge clk);
    check("t4_beat0", bus.host_beat, 1);
    check("t4_addr0", bus.mem_addr,  32'h1FFFF);
    next_cycle();
    bus.host_wdata = 8'h5B;
    @(negedge clk);
    check("t4_beat1", bus.host_beat, 1);
    check("t4_addr1", bus.mem_addr,  32'h00000);
    next_cycle();
    @(negedge clk);
    check("t4_done", bus.host_done, 1);
    next_cycle();

    // Zero-length burst.
    start_burst(1'b1, 17'h01234, 17'd0, 8'h00);
    @(negedge clk);
    check("t5_c0_done", bus.host_done, 0);
    next_cycle();
    bus.host_req = 1'b0;
    @(negedge clk);
    check("t5_done",  bus.host_done, 1);
    check("t5_busy",  bus.host_busy, 1);
    check("t5_nbeat", bus.host_beat, 0);
    next_cycle();
    @(negedge clk);
    check("t5_pulse", bus.host_done, 0);
    check("t5_idle",  bus.host_busy, 0);
    next_cycle();
    @(negedge clk);
    check("t5_once", bus.host_done, 0);
    next_cycle();

    // Reset after the 2nd beat of a 6-byte burst.
    start_burst(1'b1, 17'h01900, 17'd6, 8'h10);
    @(negedge clk);
    next_cycle();
    bus.host_req = 1'b0;
    @(negedge clk);
    check("t6_beat0", bus.mem_addr, 32'h1900);
    next_cycle();
    bus.host_wdata = 8'h11;
    @(negedge clk);
    check("t6_beat1", bus.mem_addr, 32'h1901);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_busy",  bus.host_busy, 0);
    check("t6_beat",  bus.host_beat, 0);
    check("t6_done",  bus.host_done, 0);
    check("t6_we",    bus.mem_we,    0);
    @(negedge clk);
    check("t6_done_rst", bus.host_done, 0);
    #2;
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("t6_done_after", bus.host_done, 0);
    check("t6_busy_after", bus.host_busy, 0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 17'(32'h1900 + i);
      end else begin
        bus.cpu_req = 1'b0;
      end
      @(negedge clk);
      if (i > 0) check("t6_kept", bus.cpu_rdata, 32'h10 + i - 1);
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
